welford_div_sched: RTL and testbench
====================================

# welford_div_sched

Round-robin scheduler that shares one shift-based approximate divider (rounded log2 of the divisor, then arithmetic right shift) among NUM_REQ Welford update lanes. Each lane presents a signed numerator and an unsigned sample count. The block arbitrates between lanes, runs a 2-stage elastic pipeline, and returns the quotient tagged with the lane ID. It sits between the per-flow Welford state-update logic and the extern's result path.

## Interface
- NUM_REQ, 4: number of requesting lanes (≥2).
- DATA_WIDTH, 32: numerator/quotient width, two's complement.
- CNT_WIDTH, 20: divisor (sample count) width, unsigned.
- SHIFT_WIDTH, $clog2(CNT_WIDTH): shift-amount width.
- ID_WIDTH, $clog2(NUM_REQ): lane ID width.
- axis_aclk  in  1  sole clock; all logic rising-edge.
- axis_resetn  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-lane request valid.
- req_ready  out  NUM_REQ  per-lane accept; one-hot or zero.
- req_num  in  NUM_REQ*DATA_WIDTH  lane i numerator at [i*DATA_WIDTH +: DATA_WIDTH].
- req_cnt  in  NUM_REQ*CNT_WIDTH  lane i divisor at [i*CNT_WIDTH +: CNT_WIDTH].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_id  out  ID_WIDTH  lane that issued the result.
- rsp_quot  out  DATA_WIDTH  numerator >>> shift.
- rsp_shift  out  SHIFT_WIDTH  shift amount applied.

## Operation
- Handshake: a transfer occurs on a cycle with valid & ready. A lane holds valid and its operands stable until accepted. A lane's req_valid must not depend on req_ready.
- Arbitration: rr_ptr holds the last granted lane. The grant goes to the first lane with req_valid set, searching cyclically from rr_ptr+1. req_ready[g] = grant_valid & a_free. rr_ptr updates only on an accepted transfer.
- Stage A register: a_valid, a_id, a_num, a_cnt. a_free = !a_valid | b_free.
- Shift computation: shift = log2 of a_cnt, rounded to nearest. If P is the leading-one position, shift = P+1 when bit P-1 is 1, else P. For cnt 0 or 1, shift = 0 (pass-through, no divide). Examples: 2→1, 3→2, 4→2, 5→2, 6→3, 7→3, 12→4.
- Stage B register: b_valid, b_id, b_quot = a_num >>> shift (arithmetic, rounds toward −∞), b_shift. b_free = !b_valid | rsp_ready.
- Outputs are driven directly from the stage B registers.
- No reordering: results leave in acceptance order.
- Throughput: one result per cycle when rsp_ready stays high.

## Timing
- Reset (async assert): a_valid = b_valid = 0, rsp_valid = 0, rsp_id/rsp_quot/rsp_shift = 0, req_ready = 0, rr_ptr = NUM_REQ-1 (lane 0 wins first).
- Deassertion is used synchronously. The first accept can occur in the first cycle after release.
- Latency: accept at cycle t → rsp_valid at t+2 when not stalled.
- Backpressure:
  - While rsp_valid & !rsp_ready, stage B holds.
  - Stage A holds if it is full.
  - req_ready drops to 0 in the same cycle stage A cannot accept.
  - No result is dropped or duplicated.
- Simultaneous drain and fill: a stage may load in the same cycle its contents advance.
- Single requester: a lane held continuously valid is accepted every cycle.
- All lanes valid: grants rotate 0,1,2,3,0,… with each lane served once per NUM_REQ accepts.
- Reset mid-operation: in-flight results are discarded; no response is emitted for them.

## Structure
- Shared package welford_pkg holds:
  - Width helpers: SHIFT_WIDTH and ID_WIDTH derivation.
  - The lane-slice index macro/function.
  - The pass-through threshold constant (cnt ≤ 1).
- One sub-module: the existing bitwise_log2 unit, instantiated between stage A and stage B with INPUT_WIDTH = CNT_WIDTH.
- Arbiter and pipeline stay in this module.

## Test plan
- Reset then single request: lane 0, num=100, cnt=6 → two cycles later rsp_valid=1, rsp_id=0, rsp_shift=3, rsp_quot=12.
- Negative and edge divisors:
  - num=−100, cnt=4 → quot −25, shift 2.
  - num=−7, cnt=2 → −4.
  - num=55, cnt=0 → 55, shift 0.
  - num=55, cnt=1 → 55, shift 0.
- Fairness: all 4 lanes held valid for 8 accepts → rsp_id sequence 0,1,2,3,0,1,2,3. req_ready is one-hot every cycle.
- Backpressure: rsp_ready low for 5 cycles with lanes valid → at most 2 accepts, then req_ready=0. Outputs stay stable. After release, every result is delivered in order with no loss.
- Rounding sweep: cnt=2..16 with num=65536 → quotients match the rounded-log2 rule (e.g. cnt=5 → 16384, cnt=6 → 8192, cnt=12 → 4096).
- Async reset asserted with both stages full → rsp_valid falls immediately. After release, there are no stale responses and lane 0 is granted first.

Source files
------------

// File: rtl/welford_pkg.sv
// Shared helpers for the Welford divide scheduler: width derivation,
// lane-slice indexing and the divisor pass-through threshold.
package welford_pkg;

  // Divisors at or below this value bypass the divide (shift of zero).
  localparam int unsigned PASS_THRU_MAX = 1;

  function automatic int unsigned shift_width(input int unsigned cnt_w);
    return $clog2(cnt_w);
  endfunction

  function automatic int unsigned id_width(input int unsigned num_lanes);
    return (num_lanes > 1) ? $clog2(num_lanes) : 1;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/bitwise_log2.sv
// Rounded log2 of an unsigned value: leading-one position, plus one when the
// bit just below it is set. Values 0 and 1 map to zero.
module bitwise_log2
  import welford_pkg::*;
#(
  parameter int INPUT_WIDTH = 20,
  parameter int SHIFT_WIDTH = shift_width(INPUT_WIDTH)
) (
  input  logic [INPUT_WIDTH-1:0] value,
  output logic [SHIFT_WIDTH-1:0] shift
);

  int   lead;
  logic round_up;

  always_comb begin
    lead     = 0;
    round_up = 1'b0;
    // Scan upward so the final hit is the most significant one.
    for (int i = 1; i < INPUT_WIDTH; i++) begin
      if (value[i]) begin
        lead     = i;
        round_up = value[i-1];
      end
    end
    shift = '0;
    if (value > INPUT_WIDTH'(PASS_THRU_MAX)) begin
      shift = SHIFT_WIDTH'(lead + int'(round_up));
    end
  end

endmodule

// File: rtl/welford_div_sched.sv
// Round-robin scheduler sharing one shift-based approximate divider among
// NUM_REQ lanes through a 2-stage elastic pipeline; results carry the lane ID.
module welford_div_sched
  import welford_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int CNT_WIDTH   = 20,
  parameter int SHIFT_WIDTH = shift_width(CNT_WIDTH),
  parameter int ID_WIDTH    = id_width(NUM_REQ)
) (
  input  logic                            axis_aclk,
  input  logic                            axis_resetn,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_num,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]    req_cnt,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_WIDTH-1:0]             rsp_id,
  output logic [DATA_WIDTH-1:0]           rsp_quot,
  output logic [SHIFT_WIDTH-1:0]          rsp_shift
);

  logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic                   a_valid_q, a_valid_d;
  logic [ID_WIDTH-1:0]    a_id_q, a_id_d;
  logic [DATA_WIDTH-1:0]  a_num_q, a_num_d;
  logic [CNT_WIDTH-1:0]   a_cnt_q, a_cnt_d;
  logic                   b_valid_q, b_valid_d;
  logic [ID_WIDTH-1:0]    b_id_q, b_id_d;
  logic [DATA_WIDTH-1:0]  b_quot_q, b_quot_d;
  logic [SHIFT_WIDTH-1:0] b_shift_q, b_shift_d;

  logic                   grant_valid;
  logic [ID_WIDTH-1:0]    grant_id;
  logic [DATA_WIDTH-1:0]  sel_num;
  logic [CNT_WIDTH-1:0]   sel_cnt;
  logic                   a_free, b_free, accept;
  logic [SHIFT_WIDTH-1:0] shift_w;

  assign b_free = !b_valid_q || rsp_ready;
  assign a_free = !a_valid_q || b_free;
  // Reset gates the handshake so no lane sees ready while the block is held.
  assign accept = grant_valid && a_free && axis_resetn;

  // Walk from farthest to nearest so the nearest valid lane after rr_ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      logic [ID_WIDTH-1:0] idx;
      idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    sel_num = '0;
    sel_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_WIDTH'(i)) begin
        sel_num = req_num[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
        sel_cnt = req_cnt[lane_lsb(i, CNT_WIDTH) +: CNT_WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  bitwise_log2 #(
    .INPUT_WIDTH (CNT_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_log2 (
    .value (a_cnt_q),
    .shift (shift_w)
  );

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    a_valid_d = a_valid_q;
    a_id_d    = a_id_q;
    a_num_d   = a_num_q;
    a_cnt_d   = a_cnt_q;
    b_valid_d = b_valid_q;
    b_id_d    = b_id_q;
    b_quot_d  = b_quot_q;
    b_shift_d = b_shift_q;

    if (accept) begin
      rr_ptr_d = grant_id;
    end

    if (a_free) begin
      a_valid_d = accept;
      if (accept) begin
        a_id_d  = grant_id;
        a_num_d = sel_num;
        a_cnt_d = sel_cnt;
      end
    end

    if (b_free) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_id_d    = a_id_q;
        b_quot_d  = $signed(a_num_q) >>> shift_w;
        b_shift_d = shift_w;
      end
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      rr_ptr_q  <= ID_WIDTH'(NUM_REQ - 1);
      a_valid_q <= 1'b0;
      a_id_q    <= '0;
      a_num_q   <= '0;
      a_cnt_q   <= '0;
      b_valid_q <= 1'b0;
      b_id_q    <= '0;
      b_quot_q  <= '0;
      b_shift_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      a_valid_q <= a_valid_d;
      a_id_q    <= a_id_d;
      a_num_q   <= a_num_d;
      a_cnt_q   <= a_cnt_d;
      b_valid_q <= b_valid_d;
      b_id_q    <= b_id_d;
      b_quot_q  <= b_quot_d;
      b_shift_q <= b_shift_d;
    end
  end

  assign rsp_valid = b_valid_q;
  assign rsp_id    = b_id_q;
  assign rsp_quot  = b_quot_q;
  assign rsp_shift = b_shift_q;

endmodule

// File: tb/tb_welford_div_sched.sv
// Scoreboard bench for welford_div_sched: directed vectors push hand-computed
// results; a monitor pops and compares on every delivered response.
module tb_welford_div_sched;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int CW = 20;
  localparam int SW = 5;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              axis_resetn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_num;
  logic [NR*CW-1:0]  req_cnt;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [DW-1:0]     rsp_quot;
  logic [SW-1:0]     rsp_shift;

  always #5 clk = ~clk;

  welford_div_sched #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .axis_aclk   (clk),
    .axis_resetn (axis_resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_num     (req_num),
    .req_cnt     (req_cnt),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_quot    (rsp_quot),
    .rsp_shift   (rsp_shift)
  );

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] quot;
    logic [SW-1:0] shift;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Per-lane operands for multi-lane tests, with hand-computed results.
  // 1000/4=250; -1000/8=-125; 7 pass-through; 100 -> shift 7, -1>>>7 = -1.
  localparam logic [DW-1:0] F_NUM   [NR] = '{32'd1000, -32'sd1000, 32'd7, -32'sd1};
  localparam logic [CW-1:0] F_CNT   [NR] = '{20'd3, 20'd8, 20'd1, 20'd100};
  localparam logic [DW-1:0] F_QUOT  [NR] = '{32'd250, -32'sd125, 32'd7, -32'sd1};
  localparam logic [SW-1:0] F_SHIFT [NR] = '{5'd2, 5'd3, 5'd0, 5'd7};

  // Rounded log2 for cnt = 2..16.
  localparam int SWEEP_SH [15] = '{1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 4, 4, 4, 4, 4};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [IW-1:0] id, input logic [DW-1:0] q, input logic [SW-1:0] s);
    rsp_t e;
    e.id = id;
    e.quot = q;
    e.shift = s;
    exp_q.push_back(e);
  endtask

  task automatic set_lane(input int lane, input logic [DW-1:0] num, input logic [CW-1:0] cnt);
    req_num[lane*DW +: DW] = num;
    req_cnt[lane*CW +: CW] = cnt;
  endtask

  task automatic set_all_lanes();
    for (int i = 0; i < NR; i++) set_lane(i, F_NUM[i], F_CNT[i]);
  endtask

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (axis_resetn && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: id %0d quot 0x%0h shift %0d, none expected",
                 rsp_id, rsp_quot, rsp_shift);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_quot", rsp_quot, e.quot);
        check("rsp_shift", rsp_shift, e.shift);
      end
    end
  end

  task automatic wait_drain();
    bit ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0) ok = 1;
    end
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Single lane, new operands each call; back-to-back calls must be accepted at once.
  task automatic send_vec(input int lane, input logic [DW-1:0] num, input logic [CW-1:0] cnt,
                          input logic [DW-1:0] q, input logic [SW-1:0] s);
    bit got = 0;
    push(IW'(lane), q, s);
    set_lane(lane, num, cnt);
    req_valid = '0;
    req_valid[lane] = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[lane]) begin
        got = 1;
        check("single_lane_accept_cycle", k, 0);
      end
      @(posedge clk);
      #1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: lane %0d not accepted, expected acceptance", lane);
    end
  endtask

  // Hold the masked lanes valid for n_acc accepts; optionally stall rsp_ready.
  task automatic run_lanes(input logic [NR-1:0] mask, input int n_acc, input int stall);
    int            cnt = 0;
    bit            done = 0;
    logic [IW-1:0] s_id;
    logic [DW-1:0] s_q;
    logic [SW-1:0] s_s;
    if (stall > 0) rsp_ready = 1'b0;
    req_valid = mask;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      if (stall > 0 && cyc >= 3 && cyc <= stall) begin
        check("bp_req_ready_zero", req_ready, 0);
        check("bp_rsp_valid_held", rsp_valid, 1);
        if (cyc == 3) begin
          s_id = rsp_id;
          s_q  = rsp_quot;
          s_s  = rsp_shift;
        end else begin
          check("bp_stable_id", rsp_id, s_id);
          check("bp_stable_quot", rsp_quot, s_q);
          check("bp_stable_shift", rsp_shift, s_s);
        end
      end else begin
        check("req_ready_onehot", $onehot(req_ready), 1);
      end
      if (|(req_valid & req_ready)) cnt++;
      if (stall > 0 && cyc == stall) check("bp_accept_count", cnt, 2);
      @(posedge clk);
      #1;
      if (stall > 0 && cyc == stall) rsp_ready = 1'b1;
      if (cnt >= n_acc) begin
        req_valid = '0;
        done = 1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: %0d accepts, expected %0d", cnt, n_acc);
      req_valid = '0;
      rsp_ready = 1'b1;
    end
  endtask

  initial begin
    axis_resetn = 1'b0;
    rsp_ready   = 1'b1;
    req_num     = '0;
    req_cnt     = '0;
    set_all_lanes();
    req_valid   = '1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_quot", rsp_quot, 0);
    check("reset_rsp_shift", rsp_shift, 0);
    check("reset_req_ready", req_ready, 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    axis_resetn = 1'b1;

    // First request right after release; result two cycles later.
    set_lane(0, 32'd100, 20'd6);
    push(0, 32'd12, 5'd3);
    req_valid = 4'b0001;
    @(negedge clk);
    check("first_accept_ready", req_ready, 4'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("latency_t1_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    check("latency_t2_rsp_valid", rsp_valid, 1);
    wait_drain();

    // Negative numerators and edge divisors.
    send_vec(0, -32'sd100, 20'd4, -32'sd25, 5'd2);
    send_vec(0, -32'sd7,   20'd2, -32'sd4,  5'd1);
    send_vec(0, 32'd55,    20'd0, 32'd55,   5'd0);
    send_vec(0, 32'd55,    20'd1, 32'd55,   5'd0);
    req_valid = '0;
    wait_drain();

    // Rounding sweep.
    for (int c = 2; c <= 16; c++) begin
      send_vec(0, 32'd65536, CW'(c), 32'd65536 >> SWEEP_SH[c-2], SW'(SWEEP_SH[c-2]));
    end
    req_valid = '0;
    wait_drain();

    // Reset pulse to restart rotation from lane 0; outputs must clear.
    req_valid = '1;
    axis_resetn = 1'b0;
    #1;
    check("pulse_rsp_quot_cleared", rsp_quot, 0);
    check("pulse_rsp_shift_cleared", rsp_shift, 0);
    check("pulse_req_ready", req_ready, 0);
    req_valid = '0;
    @(posedge clk);
    #1;
    axis_resetn = 1'b1;

    // Fairness: all lanes valid, eight accepts.
    set_all_lanes();
    for (int n = 0; n < 8; n++) push(IW'(n % NR), F_QUOT[n % NR], F_SHIFT[n % NR]);
    run_lanes(4'b1111, 8, 0);
    wait_drain();

    // Backpressure: last grant was lane 3, so lanes 1 and 2 alternate from 1.
    for (int n = 0; n < 6; n++) begin
      push(IW'(1 + n % 2), F_QUOT[1 + n % 2], F_SHIFT[1 + n % 2]);
    end
    run_lanes(4'b0110, 6, 5);
    wait_drain();

    // Async reset with both stages full.
    set_lane(0, 32'd100, 20'd6);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    repeat (3) @(negedge clk);
    check("full_before_reset", rsp_valid, 1);
    @(posedge clk);
    #2;
    axis_resetn = 1'b0;
    #1;
    check("async_rst_rsp_valid", rsp_valid, 0);
    check("async_rst_req_ready", req_ready, 0);
    req_valid = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    axis_resetn = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_rsp", rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    set_all_lanes();
    req_valid = 4'b1111;
    #1;
    check("first_grant_after_reset", req_ready, 4'b0001);
    for (int n = 0; n < NR; n++) push(IW'(n), F_QUOT[n], F_SHIFT[n]);
    run_lanes(4'b1111, 4, 0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
